// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer_if                                          |
// | Description : Bundle of the command, ALU and result handshake signals of    |
// |               alu_cmd_sequencer.                                            |
// |   cmd_*      command push side (valid/ready, opcode, a, b)                  |
// |   alu_*      registered ALU inputs out, combinational ALU result back in    |
// |   res_*      captured result with valid/ready                               |
// |   count/busy FIFO occupancy and activity status                             |
// |   slave  : view of the sequencer itself                                     |
// |   master : view of the surrounding logic (producer, ALU, consumer)          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface alu_cmd_sequencer_if #(
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic [3:0]    alu_opcode;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [7:0]    alu_x;
  logic [7:0]    alu_y;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_x;
  logic [7:0]    res_y;
  logic [3:0]    res_opcode;
  logic          res_zero;
  logic [CW-1:0] count;
  logic          busy;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_x, alu_y, res_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, res_valid, res_x, res_y,
           res_opcode, res_zero, count, busy
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_x, alu_y, res_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, res_valid, res_x, res_y,
           res_opcode, res_zero, count, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer                                             |
// | Description : Issue stage for an 8-bit combinational ALU. Commands are      |
// |               queued in a DEPTH-entry FIFO, issued one at a time onto       |
// |               registered ALU inputs, and the ALU result is captured and     |
// |               offered downstream on a valid/ready handshake.                |
// | Ports       : clk   - rising-edge clock                                     |
// |               rst_n - asynchronous active-low reset                         |
// |               bus   - slave view of alu_cmd_sequencer_if (cmd/alu/res,      |
// |                       count, busy)                                          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [19:0]   mem [DEPTH];
  logic [19:0]   head;

  logic [3:0]    alu_opcode;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic          res_valid;
  logic [7:0]    res_x;
  logic [7:0]    res_y;
  logic [3:0]    res_opcode;
  logic          res_zero;

  logic          cmd_ready;
  logic          push;
  logic          pop;

  // Ready depends only on the registered occupancy, so a full FIFO refuses a
  // command even when a pop frees a slot on the same edge.
  assign cmd_ready = (count < CW'(DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;

  // Pops look at the registered count only: a command written on this edge is
  // not visible until the next one (no bypass path).
  assign pop = (count != '0) &&
               ((state == IDLE) || ((state == DONE) && bus.res_ready));

  assign head = mem[rd_ptr];

  // Storage array needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_valid  <= 1'b0;
      res_x      <= '0;
      res_y      <= '0;
      res_opcode <= '0;
      res_zero   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        alu_opcode <= head[19:16];
        alu_a      <= head[15:8];
        alu_b      <= head[7:0];
      end
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (pop) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable for a full cycle; sample its result.
          res_x      <= bus.alu_x;
          res_y      <= bus.alu_y;
          res_opcode <= alu_opcode;
          res_zero   <= ({bus.alu_y, bus.alu_x} == 16'h0000);
          res_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= pop ? EXEC : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_opcode = alu_opcode;
  assign bus.alu_a      = alu_a;
  assign bus.alu_b      = alu_b;
  assign bus.res_valid  = res_valid;
  assign bus.res_x      = res_x;
  assign bus.res_y      = res_y;
  assign bus.res_opcode = res_opcode;
  assign bus.res_zero   = res_zero;
  assign bus.count      = count;
  assign bus.busy       = (state != IDLE) || (count != '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_cmd_sequencer                                          |
// | Description : Self-checking bench for alu_cmd_sequencer. Provides a        |
// |               behavioural ALU, queues every accepted command as the         |
// |               expected response and checks results in order, plus          |
// |               directed latency, backpressure and reset checks.              |
// | Ports       : none                                                          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_cmd_sequencer_if #(.CW(CW)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, multiply, subtract, and a mixing function otherwise.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      4'b1010: return 16'(a) + 16'(b);
      4'b1110: return 16'(a) * 16'(b);
      4'b0101: return 16'(a) - 16'(b);
      default: return {a ^ b, a + b + {4'h0, op}};
    endcase
  endfunction

  assign {bus.alu_y, bus.alu_x} = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

  int   n_cmp = 0;
  int   n_err = 0;
  cmd_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard producer: a handshake seen mid-cycle completes on the next edge.
  always @(negedge clk) begin
    if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
      exp_q.push_back({bus.cmd_opcode, bus.cmd_a, bus.cmd_b});
    end
  end

  // Scoreboard consumer: compare every result the consumer takes.
  always @(negedge clk) begin
    cmd_t        e;
    logic [15:0] r;
    if (rst_n) begin
      chk("count_bound", 32'(bus.count <= CW'(DEPTH)), 32'd1);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.res_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          r = alu_fn(e.op, e.a, e.b);
          chk("sb_result", {16'h0, bus.res_y, bus.res_x}, {16'h0, r});
          chk("sb_opcode", 32'(bus.res_opcode), 32'(e.op));
          chk("sb_zero", 32'(bus.res_zero), 32'(r == 16'h0000));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_t c);
    bus.cmd_opcode = c.op;
    bus.cmd_a      = c.a;
    bus.cmd_b      = c.b;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op = 4'($urandom_range(0, 15));
    c.a  = 8'($urandom);
    c.b  = 8'($urandom);
    return c;
  endfunction

  task automatic wait_res(input string nm);
    int n = 0;
    while (!bus.res_valid && n < 20) begin
      step();
      n++;
    end
    chk(nm, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((bus.busy || bus.res_valid) && n < 200) begin
      step();
      n++;
    end
    chk(nm, 32'(bus.busy), 32'd0);
  endtask

  cmd_t fill [6];
  logic acc;
  int   idx;
  int   sent;
  int   cyc;

  initial begin
    rst_n          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.res_ready  = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res", {12'h0, bus.res_opcode, bus.res_y, bus.res_x}, 32'd0);
    chk("rst_res_zero", 32'(bus.res_zero), 32'd0);
    chk("rst_alu", {12'h0, bus.alu_opcode, bus.alu_a, bus.alu_b}, 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Single add: 200 + 100 = 0x012C.
    drive({4'b1010, 8'd200, 8'd100});
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("add_count", 32'(bus.count), 32'd1);
    step();
    chk("add_alu_a", 32'(bus.alu_a), 32'd200);
    chk("add_alu_b", 32'(bus.alu_b), 32'd100);
    chk("add_alu_op", 32'(bus.alu_opcode), 32'hA);
    step();
    chk("add_res_valid", 32'(bus.res_valid), 32'd1);
    chk("add_res_x", 32'(bus.res_x), 32'h2C);
    chk("add_res_y", 32'(bus.res_y), 32'h01);
    chk("add_res_zero", 32'(bus.res_zero), 32'd0);
    step();
    chk("add_res_clear", 32'(bus.res_valid), 32'd0);
    chk("add_busy_clear", 32'(bus.busy), 32'd0);

    // Fill with backpressure: DEPTH+1 commands absorbed, then stall.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fill[i] = {4'(i + 3), 8'(i * 17 + 5), 8'(200 - i * 9)};
    end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.cmd_valid = 1'b1;
      drive(fill[(idx < 6) ? idx : 5]);
      acc = bus.cmd_ready;
      step();
      if (acc) idx++;
    end
    chk("fill_accepted", 32'(idx), 32'd5);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_result", {16'h0, bus.res_y, bus.res_x},
          {16'h0, alu_fn(fill[0].op, fill[0].a, fill[0].b)});
      step();
    end
    bus.res_ready = 1'b1;
    for (int j = 0; j < 14; j++) begin
      chk("drain_valid", 32'(bus.res_valid), 32'((j % 2 == 0) && (j <= 10)));
      acc = bus.cmd_valid && bus.cmd_ready;
      step();
      if (acc) begin
        bus.cmd_valid = 1'b0;
        idx++;
      end
    end
    chk("drain_sixth_accepted", 32'(idx), 32'd6);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Multiply then a zero result.
    drive({4'b1110, 8'h10, 8'h10});
    bus.cmd_valid = 1'b1;
    step();
    drive({4'b0101, 8'h5A, 8'h5A});
    step();
    bus.cmd_valid = 1'b0;
    wait_res("mul_timeout");
    chk("mul_res_y", 32'(bus.res_y), 32'h01);
    chk("mul_res_x", 32'(bus.res_x), 32'h00);
    chk("mul_res_zero", 32'(bus.res_zero), 32'd0);
    step();
    wait_res("zero_timeout");
    chk("zero_res", {16'h0, bus.res_y, bus.res_x}, 32'd0);
    chk("zero_res_zero", 32'(bus.res_zero), 32'd1);
    chk("zero_res_op", 32'(bus.res_opcode), 32'h5);
    step();

    // Streaming with pointer wrap, consumer always ready.
    sent = 0;
    cyc  = 0;
    while (sent < 12 && cyc < 100) begin
      drive(rand_cmd());
      bus.cmd_valid = 1'b1;
      acc = bus.cmd_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'd12);
    wait_idle("stream_idle");
    chk("stream_empty", 32'(exp_q.size()), 32'd0);

    // Random traffic on both sides.
    for (int c = 0; c < 300; c++) begin
      drive(rand_cmd());
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.res_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    wait_idle("random_idle");
    chk("random_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a result is pending and three commands are queued.
    bus.res_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(rand_cmd());
      bus.cmd_valid = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_res", {16'h0, bus.res_y, bus.res_x}, 32'd0);
    step();
    rst_n = 1'b1;
    drive({4'b1010, 8'h7F, 8'h81});
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("post_rst_alu_a", 32'(bus.alu_a), 32'h7F);
    chk("post_rst_valid_early", 32'(bus.res_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(bus.res_valid), 32'd1);
    chk("post_rst_res", {16'h0, bus.res_y, bus.res_x}, 32'h0100);
    bus.res_ready = 1'b1;
    step();
    chk("post_rst_clear", 32'(bus.res_valid), 32'd0);
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 8-bit combinational ALU.
- Buffers incoming commands (opcode, a, b) in a small FIFO and drives one command at a time onto registered ALU inputs.
- Captures the ALU's {y,x} result into a result register and presents it downstream on a valid/ready interface.
- Decouples the bursty command producer from the result consumer, with backpressure on both sides.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- CW, 3, count width = log2(DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command this cycle
- cmd_opcode  in  4  ALU opcode
- cmd_a  in  8  operand a
- cmd_b  in  8  operand b
- alu_opcode  out  4  registered opcode to ALU
- alu_a  out  8  registered operand a to ALU
- alu_b  out  8  registered operand b to ALU
- alu_x  in  8  ALU low result (combinational return)
- alu_y  in  8  ALU high result (combinational return)
- res_valid  out  1  result held on res_*
- res_ready  in  1  consumer accepts result
- res_x  out  8  captured low result
- res_y  out  8  captured high result
- res_opcode  out  4  opcode that produced the result
- res_zero  out  1  1 when {res_y,res_x} == 0
- count  out  CW  FIFO occupancy, 0..DEPTH
- busy  out  1  state != IDLE or count != 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; FIFO read/write pointers and count = 0.
  - All registered outputs = 0 (alu_*, res_*, res_valid, res_zero, busy).
  - cmd_ready = 1.
  - Reset mid-operation discards all queued and in-flight commands; no partial result survives.
- Push:
  - cmd_ready = (count < DEPTH). It is derived from registered state only, never from cmd_valid or res_ready.
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - When full, a command is not accepted even if a pop happens in the same cycle.
- FSM states IDLE, EXEC, DONE:
  - IDLE: if count != 0, pop head into alu_opcode/alu_a/alu_b -> EXEC; else stay IDLE.
  - EXEC: ALU inputs are stable for one full cycle. On the edge, capture alu_x -> res_x, alu_y -> res_y, alu_opcode -> res_opcode, res_zero = ({alu_y,alu_x} == 0), set res_valid = 1 -> DONE.
  - DONE: res_valid = 1; res_* are held stable while res_ready = 0.
    - On the edge with res_ready = 1: clear res_valid.
    - If count != 0 on that edge, pop the next command into alu_* -> EXEC; else -> IDLE.
- No FIFO bypass: a command pushed into an empty FIFO is popped no earlier than the following edge.
- Simultaneous push and pop: count is unchanged and both pointers advance; wrap-around is modulo DEPTH.
- alu_* hold their last values after DONE and in IDLE; they are not cleared.
- Latency and throughput:
  - Command accepted at edge N (FIFO previously empty, FSM IDLE) -> alu_* valid after edge N+1 -> res_valid high after edge N+2.
  - With res_ready tied high, steady-state throughput is one result per 2 cycles.
  - Results are delivered strictly in command order.
- Capacity: one command in flight plus DEPTH queued, so DEPTH+1 commands are absorbed before cmd_ready stalls while res_ready = 0.
- Widths: operands and results are fixed at 8 bits. The sequencer does not interpret the opcode; any 4-bit value is forwarded unchanged.

Test Plan:
- Reset: assert rst_n = 0 asynchronously -> all outputs 0, cmd_ready = 1, count = 0, busy = 0.
- Single add: push opcode 1010, a = 200, b = 100 at edge 0; res_ready = 1.
  - alu_a = 200, alu_b = 100 after edge 1.
  - res_valid = 1, res_x = 0x2C, res_y = 0x01, res_zero = 0 after edge 2.
  - res_valid = 0 after edge 3; busy returns to 0.
- Fill/backpressure (DEPTH = 4): res_ready = 0, cmd_valid held high with 6 distinct commands.
  - Exactly 5 are accepted; then count = 4 and cmd_ready = 0.
  - First result is held stable for 10 cycles.
  - Raising res_ready drains all results in push order, 2 cycles each, and the 6th command is then accepted.
- Multiply/zero: opcode 1110, a = 0x10, b = 0x10 -> res_y = 0x01, res_x = 0x00, res_zero = 0.
  - Then opcode 0101, a = b = 0x5A -> res_x = 0x00, res_y = 0x00, res_zero = 1, res_opcode = 0101.
- Wrap/simultaneous: with res_ready = 1, stream 12 commands at one push per cycle while cmd_ready allows.
  - Pointers wrap without loss or duplication and count never exceeds DEPTH.
  - Output sequence equals input sequence.
- Reset mid-DONE: rst_n low while res_valid = 1 and count = 3 -> res_valid = 0 and count = 0 immediately (no clock edge needed).
  - After release, the first new command completes with the normal 2-edge latency.
